// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stall requests and flush request in, stall vector and flush/redirect out.
interface pipe_ctrl_if;
    logic        stallreq_from_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic        flush_req_i;
    logic [31:0] flush_pc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;

    modport master (
        output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output flush_req_i, flush_pc_i,
        input  stall, flush, new_pc
    );

    modport slave (
        input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  flush_req_i, flush_pc_i,
        output stall, flush, new_pc
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall merge, flush sequencing and stall watchdog for the six-stage core.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    pipe_ctrl_if.slave        bus,
    output logic              stall_timeout_o,
    output logic [31:0]       stall_cycles_o,
    output logic [15:0]       flush_count_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(STALL_TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;

    logic [5:0]  stall_c;
    logic        flush_c;
    logic [31:0] new_pc_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            pend_pc_q <= '0;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        stall_c   = '0;
        flush_c   = 1'b0;
        new_pc_c  = '0;
        unique case (state_q)
            RUN: begin
                if (bus.flush_req_i) begin
                    pend_pc_d = bus.flush_pc_i;
                    stall_c   = '1;
                    state_d   = bus.stallreq_from_mem ? PEND : FLUSH;
                end else if (bus.stallreq_from_mem) begin
                    stall_c = 6'b011111;
                end else if (bus.stallreq_from_ex) begin
                    stall_c = 6'b001111;
                end else if (bus.stallreq_from_id) begin
                    stall_c = 6'b000111;
                end else if (bus.stallreq_from_if) begin
                    stall_c = 6'b000011;
                end
            end
            PEND: begin
                // Freeze everything until the data bus transaction completes.
                stall_c = '1;
                if (!bus.stallreq_from_mem) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                flush_c  = 1'b1;
                new_pc_c = pend_pc_q;
                state_d  = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        wd_cnt_d  = '0;
        timeout_d = timeout_q | (wd_cnt_q >= TIMEOUT_W);
        if (stall_c != '0) begin
            wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + 16'd1;
        end
    end

    // Stall is combinational from the requests, so force it quiet while reset is held.
    assign bus.stall       = rst ? '0 : stall_c;
    assign bus.flush       = flush_c;
    assign bus.new_pc      = new_pc_c;
    assign stall_timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if ((stall_c != '0) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if ((state_q == FLUSH) && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: table of stall-priority vectors plus flush, watchdog and reset sequences.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_timeout_o;
    logic [31:0] stall_cycles_o;
    logic [15:0] flush_count_o;

    int unsigned n_tests;
    int unsigned n_fail;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.STALL_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .stall_timeout_o (stall_timeout_o),
        .stall_cycles_o  (stall_cycles_o),
        .flush_count_o   (flush_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;        // {mem, ex, id, if}
        logic [5:0] exp_stall;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Inputs change on the falling edge; checks follow 1ns later, well before the rising edge.
    task automatic drive(input logic [3:0] req, input logic freq, input logic [31:0] pc);
        @(negedge clk);
        {bus.stallreq_from_mem, bus.stallreq_from_ex, bus.stallreq_from_id, bus.stallreq_from_if} = req;
        bus.flush_req_i = freq;
        bus.flush_pc_i  = pc;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {bus.stallreq_from_mem, bus.stallreq_from_ex, bus.stallreq_from_id, bus.stallreq_from_if} = '0;
        bus.flush_req_i = 1'b0;
        bus.flush_pc_i  = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{4'b0000, 6'b000000};
        vecs[1] = '{4'b0001, 6'b000011};
        vecs[2] = '{4'b0010, 6'b000111};
        vecs[3] = '{4'b0100, 6'b001111};
        vecs[4] = '{4'b0110, 6'b001111};
        vecs[5] = '{4'b1000, 6'b011111};
        vecs[6] = '{4'b1001, 6'b011111};
        vecs[7] = '{4'b1111, 6'b011111};
        vecs[8] = '{4'b0000, 6'b000000};

        rst = 1'b1;
        {bus.stallreq_from_mem, bus.stallreq_from_ex, bus.stallreq_from_id, bus.stallreq_from_if} = '0;
        bus.flush_req_i = 1'b0;
        bus.flush_pc_i  = '0;
        #12;
        chk("rst_stall",   32'(bus.stall), 32'h0);
        chk("rst_flush",   32'(bus.flush), 32'h0);
        chk("rst_new_pc",  bus.new_pc, 32'h0);
        chk("rst_timeout", 32'(stall_timeout_o), 32'h0);
        chk("rst_scycles", stall_cycles_o, 32'h0);
        chk("rst_fcount",  32'(flush_count_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Stall priority table.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].req, 1'b0, 32'h0);
            chk($sformatf("prio_stall[%0d]", i), 32'(bus.stall), 32'(vecs[i].exp_stall));
            chk($sformatf("prio_flush[%0d]", i), 32'(bus.flush), 32'h0);
        end

        // Flush with memory idle.
        do_reset();
        drive(4'b0000, 1'b1, 32'h0000_0040);
        chk("fi_req_stall", 32'(bus.stall), 32'h3F);
        chk("fi_req_flush", 32'(bus.flush), 32'h0);
        drive(4'b0000, 1'b0, 32'h0);
        chk("fi_flush",     32'(bus.flush), 32'h1);
        chk("fi_new_pc",    bus.new_pc, 32'h40);
        chk("fi_stall",     32'(bus.stall), 32'h0);
        drive(4'b0000, 1'b0, 32'h0);
        chk("fi_after_flush",  32'(bus.flush), 32'h0);
        chk("fi_after_new_pc", bus.new_pc, 32'h0);

        // Flush with memory busy three cycles, second request in PEND ignored.
        drive(4'b1000, 1'b1, 32'h0000_0040);
        chk("fp_c0_stall", 32'(bus.stall), 32'h3F);
        drive(4'b1000, 1'b1, 32'h0000_0080);
        chk("fp_c1_stall", 32'(bus.stall), 32'h3F);
        chk("fp_c1_flush", 32'(bus.flush), 32'h0);
        drive(4'b1000, 1'b0, 32'h0);
        chk("fp_c2_stall", 32'(bus.stall), 32'h3F);
        drive(4'b0000, 1'b0, 32'h0);
        chk("fp_m_stall",  32'(bus.stall), 32'h3F);
        chk("fp_m_flush",  32'(bus.flush), 32'h0);
        drive(4'b0000, 1'b0, 32'h0);
        chk("fp_flush",    32'(bus.flush), 32'h1);
        chk("fp_new_pc",   bus.new_pc, 32'h40);
        chk("fp_stall",    32'(bus.stall), 32'h0);
        drive(4'b0000, 1'b0, 32'h0);
        chk("fp_after_flush", 32'(bus.flush), 32'h0);

        // Watchdog: a 3-cycle stall stays below the limit of 4, a 5-cycle stall trips it.
        do_reset();
        for (int i = 0; i < 3; i++) drive(4'b0100, 1'b0, 32'h0);
        drive(4'b0000, 1'b0, 32'h0);
        drive(4'b0000, 1'b0, 32'h0);
        chk("wd_short", 32'(stall_timeout_o), 32'h0);
        for (int i = 0; i < 5; i++) begin
            drive(4'b0100, 1'b0, 32'h0);
            chk($sformatf("wd_hold[%0d]", i), 32'(stall_timeout_o), 32'h0);
        end
        drive(4'b0000, 1'b0, 32'h0);
        chk("wd_set",    32'(stall_timeout_o), 32'h1);
        drive(4'b0000, 1'b0, 32'h0);
        drive(4'b0000, 1'b0, 32'h0);
        chk("wd_sticky", 32'(stall_timeout_o), 32'h1);

        // Reset asserted while in PEND.
        do_reset();
        drive(4'b1000, 1'b1, 32'h0000_0040);
        drive(4'b1000, 1'b0, 32'h0);
        chk("rp_pend_stall", 32'(bus.stall), 32'h3F);
        rst = 1'b1;
        #1;
        chk("rp_stall",  32'(bus.stall), 32'h0);
        chk("rp_flush",  32'(bus.flush), 32'h0);
        chk("rp_new_pc", bus.new_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 1'b0, 32'h0);
            chk($sformatf("rp_no_flush[%0d]", i), 32'(bus.flush), 32'h0);
        end

        // Performance counters: 7 stalled cycles plus two idle-memory flushes.
        do_reset();
        for (int i = 0; i < 7; i++) drive(4'b0100, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            drive(4'b0000, 1'b1, 32'h0000_0100);
            drive(4'b0000, 1'b0, 32'h0);
        end
        drive(4'b0000, 1'b0, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_cycles", stall_cycles_o, 32'd9);
        chk("perf_flush_count",  32'(flush_count_o), 32'd2);
`else
        chk("perf_stall_cycles", stall_cycles_o, 32'd0);
        chk("perf_flush_count",  32'(flush_count_o), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the six-stage CPU core: it merges stall requests from IF, ID, EX and MEM into the `stall[5:0]` vector consumed by every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It also sequences pipeline flushes, holding a flush until the memory stage is idle and then issuing a one-cycle `flush` with the redirect PC. A watchdog counts consecutive stalled cycles and flags a hung pipeline.

## Interface
- `STALL_TIMEOUT`, default 1024: consecutive stalled cycles before `stall_timeout_o` sets; legal range 1..65535.
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `stallreq_from_if`  in  1  instruction fetch waiting on bus.
- `stallreq_from_id`  in  1  load-use hazard in decode.
- `stallreq_from_ex`  in  1  multi-cycle EX operation (mul/div) busy.
- `stallreq_from_mem`  in  1  data bus transaction in flight.
- `flush_req_i`  in  1  exception/redirect request, single-cycle pulse.
- `flush_pc_i`  in  32  redirect target, valid with `flush_req_i`.
- `stall`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- `flush`  out  1  clear all pipeline registers this cycle.
- `new_pc`  out  32  PC to load while `flush` = 1.
- `stall_timeout_o`  out  1  sticky hang flag.
- `stall_cycles_o`  out  32  total stalled cycles (see Configuration).
- `flush_count_o`  out  16  total flushes issued (see Configuration).

## Operation
- States: RUN, PEND, FLUSH. Reset state RUN.
- RUN, `flush_req_i` = 0: `stall` from requests by priority mem > ex > id > if: 6'b011111, 6'b001111, 6'b000111, 6'b000011; none -> 6'b000000.
- RUN, `flush_req_i` = 1: capture `flush_pc_i` into pending PC; `stall` = 6'b111111 this cycle; next state FLUSH if `stallreq_from_mem` = 0, else PEND.
- PEND: `stall` = 6'b111111; next state FLUSH in the cycle after `stallreq_from_mem` is sampled 0; otherwise remain.
- FLUSH: `flush` = 1, `new_pc` = pending PC, `stall` = 6'b000000; next state RUN unconditionally.
- `flush_req_i` in PEND or FLUSH is ignored; the first captured PC wins.
- `new_pc` = 32'h0 whenever `flush` = 0.
- Watchdog: 16-bit counter increments every cycle `stall` != 0 (RUN or PEND); clears when `stall` = 0. When count reaches `STALL_TIMEOUT`, `stall_timeout_o` sets and stays set until reset. Counter saturates at 16'hFFFF.
- Reset mid-operation (including PEND/FLUSH): pending flush discarded; state RUN.
- Reset values: `stall` 0, `flush` 0, `new_pc` 0, `stall_timeout_o` 0, `stall_cycles_o` 0, `flush_count_o` 0; internal counter and pending PC 0.

## Timing
- `stall` is combinational from inputs and state: a request in cycle N stalls the pipeline in cycle N.
- `flush`/`new_pc` are decoded from state; earliest `flush` is cycle N+1 after `flush_req_i` in cycle N, lasting exactly one cycle.
- Flush with mem busy: `flush` in cycle M+1, where M is the first cycle in PEND with `stallreq_from_mem` = 0.
- `stall_timeout_o` rises the cycle after the counter reaches `STALL_TIMEOUT`.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: `stall_cycles_o` increments each cycle `stall` != 0. `flush_count_o` increments on each cycle in FLUSH. Both saturate at all-ones and reset to 0.
- Undefined: both counters are not built; `stall_cycles_o` and `flush_count_o` are driven constant 0.

## Test plan
- `stallreq_from_id` = 1 and `stallreq_from_ex` = 1 in the same cycle -> `stall` = 6'b001111 in that cycle; all requests low -> 6'b000000.
- `flush_req_i` pulse with `flush_pc_i` = 32'h0000_0040 and mem idle -> `stall` = 6'b111111 in that cycle. Next cycle `flush` = 1, `new_pc` = 32'h40, `stall` = 0. The following cycle `flush` = 0 and `new_pc` = 0.
- `flush_req_i` with `stallreq_from_mem` high for 3 cycles -> `stall` = 6'b111111 throughout; `flush` asserts exactly one cycle after mem drops. A second `flush_req_i` (PC 32'h80) during PEND -> `new_pc` = 32'h40.
- `STALL_TIMEOUT` = 4, `stallreq_from_ex` held 5 cycles -> `stall_timeout_o` = 1 and remains 1 after the request drops. A 3-cycle stall from reset never sets it.
- Assert `rst` while in PEND -> all outputs 0 immediately; after release, `flush` stays 0 with no new request.
- With `PIPE_CTRL_PERF_EN`: 7 stalled cycles plus 2 flushes -> `stall_cycles_o` ≥ 7 (including freeze cycles) and `flush_count_o` = 2. Without the macro, both outputs are 0.
